// File: rtl/pulse_cmd_issue_queue.sv
// Pulse command issue queue: buffers {env_id, length} commands in a small
// circular FIFO and hands each non-zero-length command to the pulse length
// counter as a one-cycle load whenever the counter is idle. Zero-length
// commands are dropped at the head without a load. Also tracks the envelope
// of the pulse in flight and strobes pulse_done when the counter finishes.
module pulse_cmd_issue_queue #(
  parameter int unsigned LENGTH_WIDTH = 7,
  parameter int unsigned ENV_ID_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PTR_WIDTH    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [LENGTH_WIDTH-1:0] cmd_length,
  input  logic [ENV_ID_WIDTH-1:0] cmd_env_id,
  input  logic                    flush,
  input  logic                    counter_running,
  output logic                    set_counter,
  output logic [LENGTH_WIDTH-1:0] length_out,
  output logic [ENV_ID_WIDTH-1:0] active_env_id,
  output logic                    pulse_done,
  output logic [PTR_WIDTH:0]      fifo_count,
  output logic                    fifo_empty,
  output logic                    fifo_full
);

  localparam logic [PTR_WIDTH:0] FullCount = (PTR_WIDTH + 1)'(FIFO_DEPTH);

  // Entry storage, split by field.
  logic [LENGTH_WIDTH-1:0] len_mem [FIFO_DEPTH];
  logic [ENV_ID_WIDTH-1:0] env_mem [FIFO_DEPTH];

  logic [PTR_WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0]      count_q, count_d;
  logic [ENV_ID_WIDTH-1:0] active_env_q, active_env_d;
  logic                    running_q;

  logic                    push;
  logic                    pop;
  logic [LENGTH_WIDTH-1:0] head_len;
  logic [ENV_ID_WIDTH-1:0] head_env;

  // Handshake, head decode and issue strobes; all from registers plus
  // flush/counter_running, so there is no path from cmd_valid to set_counter.
  always_comb begin
    fifo_empty  = (count_q == '0);
    fifo_full   = (count_q == FullCount);
    cmd_ready   = !fifo_full && !flush;
    push        = cmd_valid && cmd_ready;
    pop         = !fifo_empty && !counter_running && !flush;
    head_len    = len_mem[rd_ptr_q];
    head_env    = env_mem[rd_ptr_q];
    set_counter = pop && (head_len != '0);
    length_out  = head_len;
    // running_q is the previous-cycle counter_running; a falling edge means
    // the counter just reached zero.
    pulse_done  = running_q && !counter_running;
    fifo_count  = count_q;
    active_env_id = active_env_q;
  end

  // Next-state for pointers, occupancy and the in-flight envelope.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    active_env_d = active_env_q;
    if (flush) begin
      // Clears the queue only; the counter and active envelope are untouched.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (set_counter) begin
        active_env_d = head_env;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      active_env_q <= '0;
      running_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      active_env_q <= active_env_d;
      running_q    <= counter_running;
    end
  end

  // Entry storage write; cleared on reset so length_out is never X.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        len_mem[i] <= '0;
        env_mem[i] <= '0;
      end
    end else if (push) begin
      len_mem[wr_ptr_q] <= cmd_length;
      env_mem[wr_ptr_q] <= cmd_env_id;
    end
  end

endmodule
